position_overlay: RTL and testbench



---
 rtl/position_overlay_if.sv | 32 +++
 rtl/position_overlay.sv | 150 +++++++++++++++
 tb/tb_position_overlay.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/position_overlay_if.sv
// Bus between the pixel pipeline, the centroid measurement block and the overlay stage.
// The master drives pixel, colour and position inputs; the slave returns the overlaid colour and lock status.
interface position_overlay_if #(
   parameter int INPUT_WIDTH = 11,
   parameter int COLOR_WIDTH = 10
);
   logic                   enable;
   logic [INPUT_WIDTH-1:0] vga_x;
   logic [INPUT_WIDTH-1:0] vga_y;
   logic [INPUT_WIDTH-1:0] x_position;
   logic [INPUT_WIDTH-1:0] y_position;
   logic                   valid_position;
   logic [COLOR_WIDTH-1:0] in_red;
   logic [COLOR_WIDTH-1:0] in_green;
   logic [COLOR_WIDTH-1:0] in_blue;
   logic [COLOR_WIDTH-1:0] out_red;
   logic [COLOR_WIDTH-1:0] out_green;
   logic [COLOR_WIDTH-1:0] out_blue;
   logic                   locked;

   modport master (
      output enable, vga_x, vga_y, x_position, y_position, valid_position,
             in_red, in_green, in_blue,
      input  out_red, out_green, out_blue, locked
   );

   modport slave (
      input  enable, vga_x, vga_y, x_position, y_position, valid_position,
             in_red, in_green, in_blue,
      output out_red, out_green, out_blue, locked
   );
endinterface

// File: rtl/position_overlay.sv
// Draws a one-pixel box around the latest committed centroid on the VGA stream,
// green while results are fresh, yellow while coasting, hidden once results go stale.
module position_overlay #(
   parameter int INPUT_WIDTH  = 11,
   parameter int COLOR_WIDTH  = 10,
   parameter int FRAME_X_MAX  = 640,
   parameter int FRAME_Y_MAX  = 480,
   parameter int BOX_HALF     = 8,
   parameter int STALE_FRAMES = 4
) (
   input  logic               clk,
   input  logic               areset,
   position_overlay_if.slave  bus
);

   localparam int W = INPUT_WIDTH;
   localparam logic [W:0] HALF_EXT = (W+1)'(BOX_HALF);
   localparam logic [W:0] X_LIMIT  = (W+1)'(FRAME_X_MAX - 1);
   localparam logic [W:0] Y_LIMIT  = (W+1)'(FRAME_Y_MAX - 1);
   localparam logic [3:0] STALE_LIMIT = 4'(STALE_FRAMES);
   localparam logic [COLOR_WIDTH-1:0] C_ONES = '1;
   localparam logic [COLOR_WIDTH-1:0] C_ZERO = '0;

   typedef enum logic [1:0] {
      NO_LOCK  = 2'd0,
      LOCKED   = 2'd1,
      COASTING = 2'd2
   } state_t;

   // Widened by one bit so subtract/add can be clamped instead of wrapping.
   function automatic logic [W-1:0] sat_low(input logic [W-1:0] c);
      logic [W:0] ext;
      ext = {1'b0, c};
      if (ext < HALF_EXT) sat_low = '0;
      else                sat_low = W'(ext - HALF_EXT);
   endfunction

   function automatic logic [W-1:0] sat_high(input logic [W-1:0] c, input logic [W:0] limit);
      logic [W:0] ext;
      ext = {1'b0, c} + HALF_EXT;
      if (ext > limit) sat_high = W'(limit);
      else             sat_high = W'(ext);
   endfunction

   state_t           state;
   logic             locked_r;
   logic [3:0]       stale_cnt;
   logic [3:0]       stale_inc;
   logic             pending_flag;
   logic [W-1:0]     pending_x, pending_y;
   logic [W-1:0]     box_left, box_right, box_top, box_bottom;
   logic             frame_start;
   logic             marker;
   logic [COLOR_WIDTH-1:0] red_r, green_r, blue_r;

   assign frame_start = (bus.vga_x == '0) && (bus.vga_y == '0);
   assign stale_inc   = stale_cnt + 4'd1;

   always_comb begin
      marker = 1'b0;
      if ((bus.vga_x == box_left || bus.vga_x == box_right) &&
          (bus.vga_y >= box_top) && (bus.vga_y <= box_bottom))
         marker = 1'b1;
      if ((bus.vga_y == box_top || bus.vga_y == box_bottom) &&
          (bus.vga_x >= box_left) && (bus.vga_x <= box_right))
         marker = 1'b1;
   end

   // Capture, commit and freshness tracking; a strobe coinciding with frame start
   // is captured after the commit because the later assignment to pending_flag wins.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state        <= NO_LOCK;
         locked_r     <= 1'b0;
         stale_cnt    <= '0;
         pending_flag <= 1'b0;
         pending_x    <= '0;
         pending_y    <= '0;
         box_left     <= '0;
         box_right    <= '0;
         box_top      <= '0;
         box_bottom   <= '0;
      end else if (!bus.enable) begin
         state        <= NO_LOCK;
         locked_r     <= 1'b0;
         stale_cnt    <= '0;
         pending_flag <= 1'b0;
         pending_x    <= '0;
         pending_y    <= '0;
         box_left     <= '0;
         box_right    <= '0;
         box_top      <= '0;
         box_bottom   <= '0;
      end else begin
         if (frame_start) begin
            if (pending_flag) begin
               box_left     <= sat_low(pending_x);
               box_right    <= sat_high(pending_x, X_LIMIT);
               box_top      <= sat_low(pending_y);
               box_bottom   <= sat_high(pending_y, Y_LIMIT);
               pending_flag <= 1'b0;
               state        <= LOCKED;
               locked_r     <= 1'b1;
               stale_cnt    <= '0;
            end else if (state != NO_LOCK) begin
               if (stale_inc == STALE_LIMIT) begin
                  state     <= NO_LOCK;
                  locked_r  <= 1'b0;
                  stale_cnt <= '0;
               end else begin
                  state     <= COASTING;
                  locked_r  <= 1'b1;
                  stale_cnt <= stale_inc;
               end
            end
         end
         if (bus.valid_position) begin
            pending_x    <= bus.x_position;
            pending_y    <= bus.y_position;
            pending_flag <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         red_r   <= '0;
         green_r <= '0;
         blue_r  <= '0;
      end else if (bus.enable && marker && state == LOCKED) begin
         red_r   <= C_ZERO;
         green_r <= C_ONES;
         blue_r  <= C_ZERO;
      end else if (bus.enable && marker && state == COASTING) begin
         red_r   <= C_ONES;
         green_r <= C_ONES;
         blue_r  <= C_ZERO;
      end else begin
         red_r   <= bus.in_red;
         green_r <= bus.in_green;
         blue_r  <= bus.in_blue;
      end
   end

   assign bus.out_red   = red_r;
   assign bus.out_green = green_r;
   assign bus.out_blue  = blue_r;
   assign bus.locked    = locked_r;

endmodule

// File: tb/tb_position_overlay.sv
// Bench for position_overlay: directed scenarios plus randomized traffic,
// every cycle compared against a frame-level behavioural model.
module tb_position_overlay;

   localparam int IW = 11;
   localparam int CW = 10;
   localparam int XMAX = 640;
   localparam int YMAX = 480;
   localparam int BH = 8;
   localparam int STALE = 4;

   localparam logic [29:0] GREEN   = {10'h000, 10'h3FF, 10'h000};
   localparam logic [29:0] YELLOW  = {10'h3FF, 10'h3FF, 10'h000};
   localparam logic [29:0] PASS155 = {10'h155, 10'h155, 10'h155};

   logic clk = 1'b0;
   logic areset;
   always #5 clk = ~clk;

   position_overlay_if #(.INPUT_WIDTH(IW), .COLOR_WIDTH(CW)) bus ();

   position_overlay #(
      .INPUT_WIDTH(IW), .COLOR_WIDTH(CW), .FRAME_X_MAX(XMAX), .FRAME_Y_MAX(YMAX),
      .BOX_HALF(BH), .STALE_FRAMES(STALE)
   ) dut (
      .clk(clk),
      .areset(areset),
      .bus(bus.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: mode 0 = no lock, 1 = locked, 2 = coasting.
   int m_mode, m_px, m_py, m_ax, m_ay, m_stale;
   bit m_pf;

   function automatic void model_clear();
      m_mode = 0; m_px = 0; m_py = 0; m_ax = 0; m_ay = 0; m_stale = 0; m_pf = 0;
   endfunction

   function automatic bit on_box(input int x, input int y);
      int l, r, t, b;
      l = (m_ax - BH < 0) ? 0 : m_ax - BH;
      r = (m_ax + BH > XMAX - 1) ? XMAX - 1 : m_ax + BH;
      t = (m_ay - BH < 0) ? 0 : m_ay - BH;
      b = (m_ay + BH > YMAX - 1) ? YMAX - 1 : m_ay + BH;
      return ((x == l || x == r) && y >= t && y <= b) ||
             ((y == t || y == b) && x >= l && x <= r);
   endfunction

   function automatic logic [29:0] rgb_out();
      return {bus.out_red, bus.out_green, bus.out_blue};
   endfunction

   task automatic tick();
      logic [29:0] exp_rgb;
      int x, y;
      x = int'(bus.vga_x);
      y = int'(bus.vga_y);
      exp_rgb = {bus.in_red, bus.in_green, bus.in_blue};
      if (bus.enable && m_mode == 1 && on_box(x, y)) exp_rgb = GREEN;
      else if (bus.enable && m_mode == 2 && on_box(x, y)) exp_rgb = YELLOW;
      if (!bus.enable) model_clear();
      else begin
         if (x == 0 && y == 0) begin
            if (m_pf) begin
               m_ax = m_px; m_ay = m_py; m_pf = 0; m_mode = 1; m_stale = 0;
            end else if (m_mode != 0) begin
               m_stale++;
               m_mode = 2;
               if (m_stale == STALE) begin m_mode = 0; m_stale = 0; end
            end
         end
         if (bus.valid_position) begin
            m_px = int'(bus.x_position); m_py = int'(bus.y_position); m_pf = 1;
         end
      end
      @(posedge clk); #1;
      check("pixel", 64'(rgb_out()), 64'(exp_rgb));
      check("locked", 64'(bus.locked), 64'(m_mode != 0));
   endtask

   task automatic pixel(input int x, input int y);
      bus.vga_x = IW'(x); bus.vga_y = IW'(y); bus.valid_position = 1'b0;
      tick();
   endtask

   task automatic strobe_at(input int px, input int py, input int x, input int y);
      bus.x_position = IW'(px); bus.y_position = IW'(py); bus.valid_position = 1'b1;
      bus.vga_x = IW'(x); bus.vga_y = IW'(y);
      tick();
      bus.valid_position = 1'b0;
   endtask

   task automatic set_colour(input int r, input int g, input int b);
      bus.in_red = CW'(r); bus.in_green = CW'(g); bus.in_blue = CW'(b);
   endtask

   initial begin
      areset = 1'b1;
      bus.enable = 1'b0; bus.valid_position = 1'b0;
      bus.vga_x = '0; bus.vga_y = '0; bus.x_position = '0; bus.y_position = '0;
      set_colour(0, 0, 0);
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check("reset_rgb", 64'(rgb_out()), 64'd0);
      check("reset_locked", 64'(bus.locked), 64'd0);
      areset = 1'b0;

      bus.enable = 1'b1;
      set_colour(10'h155, 10'h155, 10'h155);
      pixel(5, 5);
      check("release_pass", 64'(rgb_out()), 64'(PASS155));

      // Centre lock and the four box edges
      strobe_at(320, 240, 100, 100);
      pixel(0, 0);
      check("lock_up", 64'(bus.locked), 64'd1);
      pixel(312, 240); check("left_edge",   64'(rgb_out()), 64'(GREEN));
      pixel(328, 235); check("right_edge",  64'(rgb_out()), 64'(GREEN));
      pixel(320, 232); check("top_edge",    64'(rgb_out()), 64'(GREEN));
      pixel(320, 248); check("bottom_edge", 64'(rgb_out()), 64'(GREEN));
      pixel(320, 240); check("centre_pass", 64'(rgb_out()), 64'(PASS155));

      // Clamping near the corner
      strobe_at(3, 475, 50, 50);
      pixel(0, 0);
      pixel(0, 470);    check("clamp_left",   64'(rgb_out()), 64'(GREEN));
      pixel(11, 470);   check("clamp_right",  64'(rgb_out()), 64'(GREEN));
      pixel(5, 467);    check("clamp_top",    64'(rgb_out()), 64'(GREEN));
      pixel(5, 479);    check("clamp_bottom", 64'(rgb_out()), 64'(GREEN));
      pixel(2043, 470); check("no_wrap_x",    64'(rgb_out()), 64'(PASS155));
      pixel(5, 483);    check("no_over_y",    64'(rgb_out()), 64'(PASS155));

      // Coasting then drop
      for (int f = 0; f < 3; f++) begin
         pixel(0, 0);
         check("coast_locked", 64'(bus.locked), 64'd1);
      end
      pixel(0, 470); check("coast_yellow", 64'(rgb_out()), 64'(YELLOW));
      pixel(0, 0);
      check("stale_unlock", 64'(bus.locked), 64'd0);
      pixel(0, 470); check("stale_pass", 64'(rgb_out()), 64'(PASS155));

      // Strobe coincident with frame start
      strobe_at(100, 100, 50, 50);
      strobe_at(200, 200, 0, 0);
      pixel(92, 100);  check("simul_old",     64'(rgb_out()), 64'(GREEN));
      pixel(192, 200); check("simul_new_not", 64'(rgb_out()), 64'(PASS155));
      pixel(0, 0);
      pixel(192, 200); check("simul_new",     64'(rgb_out()), 64'(GREEN));
      pixel(92, 100);  check("simul_old_not", 64'(rgb_out()), 64'(PASS155));

      // Last strobe wins, then disable mid-frame
      strobe_at(50, 60, 30, 30);
      strobe_at(70, 80, 31, 30);
      pixel(0, 0);
      pixel(62, 80); check("last_wins",    64'(rgb_out()), 64'(GREEN));
      pixel(42, 60); check("first_loses",  64'(rgb_out()), 64'(PASS155));
      bus.enable = 1'b0;
      pixel(62, 80); check("disable_pass", 64'(rgb_out()), 64'(PASS155));
      check("disable_unlock", 64'(bus.locked), 64'd0);
      bus.enable = 1'b1;
      pixel(0, 0);
      pixel(62, 80); check("reenable_nomark", 64'(rgb_out()), 64'(PASS155));

      // Asynchronous reset in the middle of a frame
      strobe_at(300, 300, 20, 20);
      pixel(0, 0);
      areset = 1'b1;
      #1;
      check("async_rgb", 64'(rgb_out()), 64'd0);
      check("async_locked", 64'(bus.locked), 64'd0);
      model_clear();
      #1 areset = 1'b0;
      pixel(0, 0);
      check("post_reset_nolock", 64'(bus.locked), 64'd0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         int px, py, sel;
         bus.enable = ($urandom_range(0, 99) != 0);
         bus.valid_position = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) begin
            bus.x_position = IW'($urandom_range(0, 2047));
            bus.y_position = IW'($urandom_range(0, 2047));
         end else begin
            bus.x_position = IW'($urandom_range(0, 660));
            bus.y_position = IW'($urandom_range(0, 500));
         end
         sel = int'($urandom_range(0, 29));
         if (sel == 0) begin
            px = 0; py = 0;
         end else if (sel < 22) begin
            px = m_ax + int'($urandom_range(0, 20)) - 10;
            py = m_ay + int'($urandom_range(0, 20)) - 10;
            if (sel < 8) px = m_ax + (($urandom_range(0, 1) == 0) ? -BH : BH);
            else if (sel < 14) py = m_ay + (($urandom_range(0, 1) == 0) ? -BH : BH);
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            if (px > 2047) px = 2047;
            if (py > 2047) py = 2047;
         end else begin
            px = int'($urandom_range(0, 700));
            py = int'($urandom_range(0, 520));
         end
         bus.vga_x = IW'(px);
         bus.vga_y = IW'(py);
         set_colour(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 1023)));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
